// File: rtl/pc_gen.sv
// ============================================================================
// Module   : pc_gen
// Brief    : Fetch-stage program counter with trap/redirect/hold priority,
//            valid/ready handshake to imem, halt/resume and fetch counting.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_gen #(
   parameter int               XLEN         = 32,
   parameter logic [XLEN-1:0]  RESET_VECTOR = 32'h0000_0000,
   parameter logic [XLEN-1:0]  TRAP_VECTOR  = 32'h0000_0100,
   parameter int               INC          = 4,
   parameter int               ALIGN_CHECK  = 1,
   parameter int               CNT_W        = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              redirect_valid,
   input  logic [XLEN-1:0]   redirect_target,
   input  logic              trap_valid,
   input  logic              halt_req,
   input  logic              resume,
   input  logic              fetch_ready,
   output logic              fetch_valid,
   output logic [XLEN-1:0]   PC,
   output logic [XLEN-1:0]   PC_plus,
   output logic              halted,
   output logic              misalign,
   output logic [XLEN-1:0]   bad_addr,
   output logic [CNT_W-1:0]  fetch_count
);

   typedef enum logic [1:0] {
      S_BOOT = 2'd0,
      S_RUN  = 2'd1,
      S_HALT = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [XLEN-1:0]    r_pc;
   logic [XLEN-1:0]    w_pc_nxt;
   logic [XLEN-1:0]    w_pc_plus;
   logic               r_misalign;
   logic               w_mis_nxt;
   logic [XLEN-1:0]    r_bad_addr;
   logic [CNT_W-1:0]   r_count;
   logic               w_fetch_valid;
   logic               w_accept;
   logic               w_hold;
   logic               w_bad;

   assign w_fetch_valid = (r_state == S_RUN);
   assign w_accept      = w_fetch_valid & fetch_ready;
   assign w_hold        = stall | (w_fetch_valid & ~fetch_ready);
   assign w_bad         = (ALIGN_CHECK != 0) && redirect_valid && (redirect_target[1:0] != 2'b00);
   assign w_pc_plus     = r_pc + XLEN'(INC);

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_mis_nxt   = 1'b0;
      case (r_state)
         S_BOOT: begin
            w_state_nxt = S_RUN;
         end
         S_RUN: begin
            if (trap_valid || w_bad) begin
               w_pc_nxt  = TRAP_VECTOR;
               w_mis_nxt = w_bad && !trap_valid;
            end else if (redirect_valid) begin
               w_pc_nxt = redirect_target;
            end else if (!w_hold) begin
               w_pc_nxt = w_pc_plus;
            end
            // Halt only once the outstanding request has been taken.
            if (halt_req && !w_hold && !trap_valid && !redirect_valid) begin
               w_state_nxt = S_HALT;
            end
         end
         S_HALT: begin
            if (trap_valid) begin
               w_pc_nxt    = TRAP_VECTOR;
               w_state_nxt = S_RUN;
            end else if (redirect_valid) begin
               if (w_bad) begin
                  w_pc_nxt  = TRAP_VECTOR;
                  w_mis_nxt = 1'b1;
               end else begin
                  w_pc_nxt = redirect_target;
               end
            end else if (resume) begin
               w_state_nxt = S_RUN;
            end
         end
         default: begin
            w_state_nxt = S_BOOT;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= S_BOOT;
         r_pc       <= RESET_VECTOR;
         r_misalign <= 1'b0;
         r_bad_addr <= '0;
         r_count    <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_pc       <= w_pc_nxt;
         r_misalign <= w_mis_nxt;
         if (w_mis_nxt) begin
            r_bad_addr <= redirect_target;
         end
         if (w_accept) begin
            r_count <= r_count + CNT_W'(1);
         end
      end
   end

   assign fetch_valid = w_fetch_valid;
   assign PC          = r_pc;
   assign PC_plus     = w_pc_plus;
   assign halted      = (r_state == S_HALT);
   assign misalign    = r_misalign;
   assign bad_addr    = r_bad_addr;
   assign fetch_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_pc_gen.sv
// ============================================================================
// Module   : tb_pc_gen
// Brief    : Directed self-checking bench for pc_gen (default build plus an
//            ALIGN_CHECK=0 / CNT_W=4 build driven by the same stimulus).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_gen;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic        trap_valid;
   logic        halt_req;
   logic        resume;
   logic        fetch_ready;

   logic        fv_a, halted_a, mis_a;
   logic [31:0] pc_a, pcp_a, bad_a, cnt_a;
   logic        fv_b, halted_b, mis_b;
   logic [31:0] pc_b, pcp_b, bad_b;
   logic [3:0]  cnt_b;

   int n_checks;
   int n_errors;

   pc_gen u_dut_a (
      .clk             (clk),
      .rst             (rst),
      .stall           (stall),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .trap_valid      (trap_valid),
      .halt_req        (halt_req),
      .resume          (resume),
      .fetch_ready     (fetch_ready),
      .fetch_valid     (fv_a),
      .PC              (pc_a),
      .PC_plus         (pcp_a),
      .halted          (halted_a),
      .misalign        (mis_a),
      .bad_addr        (bad_a),
      .fetch_count     (cnt_a)
   );

   pc_gen #(.ALIGN_CHECK(0), .CNT_W(4)) u_dut_b (
      .clk             (clk),
      .rst             (rst),
      .stall           (stall),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .trap_valid      (trap_valid),
      .halt_req        (halt_req),
      .resume          (resume),
      .fetch_ready     (fetch_ready),
      .fetch_valid     (fv_b),
      .PC              (pc_b),
      .PC_plus         (pcp_b),
      .halted          (halted_b),
      .misalign        (mis_b),
      .bad_addr        (bad_b),
      .fetch_count     (cnt_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_a(input string tag, input logic [31:0] pc, input logic fv,
                          input logic hl, input logic [31:0] cnt);
      check({tag, ".pc"},     pc_a,     pc);
      check({tag, ".fv"},     32'(fv_a),     32'(fv));
      check({tag, ".halted"}, 32'(halted_a), 32'(hl));
      check({tag, ".cnt"},    cnt_a,    cnt);
   endtask

   task automatic clear_in();
      stall           = 1'b0;
      redirect_valid  = 1'b0;
      redirect_target = 32'h0;
      trap_valid      = 1'b0;
      halt_req        = 1'b0;
      resume          = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst = 1'b0;
      fetch_ready = 1'b1;
      clear_in();

      // Reset state
      #12;
      check_a("rst", 32'h0, 1'b0, 1'b0, 32'd0);
      check("rst.mis", 32'(mis_a), 32'd0);
      check("rst.bad", bad_a, 32'h0);
      check("rst.pcplus", pcp_a, 32'h4);
      @(posedge clk); #1;
      rst = 1'b1;

      // T1: BOOT cycle then sequential fetch
      check_a("t1.boot", 32'h0, 1'b0, 1'b0, 32'd0);
      tick(); check_a("t1.run0", 32'h0, 1'b1, 1'b0, 32'd0);
      tick(); check_a("t1.pc4",  32'h4, 1'b1, 1'b0, 32'd1);
      tick(); check_a("t1.pc8",  32'h8, 1'b1, 1'b0, 32'd2);

      // T2: imem back-pressure holds PC
      fetch_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick(); check_a("t2.hold", 32'h8, 1'b1, 1'b0, 32'd2);
      end
      fetch_ready = 1'b1;
      tick(); check_a("t2.rel", 32'hC, 1'b1, 1'b0, 32'd3);

      // T3: redirect beats stall, trap beats redirect
      stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h40;
      tick(); check_a("t3.redir", 32'h40, 1'b1, 1'b0, 32'd4);
      trap_valid = 1'b1;
      tick(); check_a("t3.trap", 32'h100, 1'b1, 1'b0, 32'd5);
      clear_in();
      tick(); check_a("t3.seq", 32'h104, 1'b1, 1'b0, 32'd6);

      // T4: misaligned redirect
      redirect_valid = 1'b1; redirect_target = 32'h42;
      tick();
      check_a("t4.trap", 32'h100, 1'b1, 1'b0, 32'd7);
      check("t4.mis", 32'(mis_a), 32'd1);
      check("t4.bad", bad_a, 32'h42);
      check("t4b.pc", pc_b, 32'h42);
      check("t4b.mis", 32'(mis_b), 32'd0);
      clear_in();
      tick();
      check_a("t4.after", 32'h104, 1'b1, 1'b0, 32'd8);
      check("t4.mis_end", 32'(mis_a), 32'd0);
      check("t4.bad_keep", bad_a, 32'h42);
      check("t4b.pc2", pc_b, 32'h46);

      // T5: halt, redirect in HALT, resume, trap wakes
      redirect_valid = 1'b1; redirect_target = 32'h20;
      tick(); check_a("t5.pc20", 32'h20, 1'b1, 1'b0, 32'd9);
      clear_in(); halt_req = 1'b1;
      tick(); check_a("t5.halt", 32'h24, 1'b0, 1'b1, 32'd10);
      clear_in(); stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h30;
      tick(); check_a("t5.hredir", 32'h30, 1'b0, 1'b1, 32'd10);
      clear_in(); resume = 1'b1; halt_req = 1'b1;
      tick(); check_a("t5.resume", 32'h30, 1'b1, 1'b0, 32'd10);
      clear_in();
      tick(); check_a("t5.fetch", 32'h34, 1'b1, 1'b0, 32'd11);
      halt_req = 1'b1;
      tick(); check_a("t5.halt2", 32'h38, 1'b0, 1'b1, 32'd12);
      clear_in(); trap_valid = 1'b1;
      tick(); check_a("t5.wake", 32'h100, 1'b1, 1'b0, 32'd12);
      clear_in(); halt_req = 1'b1; fetch_ready = 1'b0;
      tick(); check_a("t5.defer", 32'h100, 1'b1, 1'b0, 32'd12);
      fetch_ready = 1'b1;
      tick(); check_a("t5.halt3", 32'h104, 1'b0, 1'b1, 32'd13);
      clear_in(); resume = 1'b1;
      tick(); check_a("t5.resume2", 32'h104, 1'b1, 1'b0, 32'd13);

      // T6: wrap, counter wrap in the narrow build, async reset mid-stall
      clear_in(); redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
      tick(); check_a("t6.top", 32'hFFFF_FFFC, 1'b1, 1'b0, 32'd14);
      check("t6.pcplus", pcp_a, 32'h0);
      clear_in();
      tick(); check_a("t6.wrap", 32'h0, 1'b1, 1'b0, 32'd15);
      tick(); check_a("t6.pc4", 32'h4, 1'b1, 1'b0, 32'd16);
      check("t6b.cnt16", 32'(cnt_b), 32'd0);
      stall = 1'b1;
      tick(); check_a("t6.stall", 32'h4, 1'b1, 1'b0, 32'd17);
      check("t6b.cnt17", 32'(cnt_b), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_a("t6.arst", 32'h0, 1'b0, 1'b0, 32'd0);
      check("t6b.arst_cnt", 32'(cnt_b), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
